// File: rtl/dot_matrix_scroller.sv
// -----------------------------------------------------------------------------
// dot_matrix_scroller
//
// Column-scanning controller for a ROWS-tall LED dot matrix. Pixel columns come
// from a run-time writable glyph RAM of N_GLYPH glyphs x COLS columns. A scan
// divider steps the displayed column; a slower step divider moves the image
// origin (base) either a whole glyph at a time (page mode) or one column at a
// time (scroll mode).
//
// Build option:
//   DOT_SCROLL_EN  defined   -> page and scroll mode, selected by `mode`
//                  undefined -> page mode only, `mode` is ignored
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   en       in   display enable; low blanks row from the next column step
//   mode     in   0 = page mode, 1 = scroll mode (DOT_SCROLL_EN builds only)
//   pause    in   freezes base; column scanning continues
//   wr_en    in   glyph RAM write strobe
//   wr_addr  in   RAM word address {glyph, column}, AW bits
//   wr_data  in   column pixel pattern, bit i drives row i
//   row      out  registered row drive for the current column
//   col      out  registered current column index
//   wrap     out  one-cycle pulse when base returns to 0
// -----------------------------------------------------------------------------
module dot_matrix_scroller #(
  parameter int  ROWS     = 16,
  parameter int  COL_W    = 4,
  parameter int  N_GLYPH  = 4,
  parameter int  SCAN_DIV = 5000,
  parameter int  STEP_DIV = 25000000,
  localparam int GW       = $clog2(N_GLYPH),
  localparam int AW       = GW + COL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             pause,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [ROWS-1:0]  wr_data,
  output logic [ROWS-1:0]  row,
  output logic [COL_W-1:0] col,
  output logic             wrap
);

  localparam int WORDS   = N_GLYPH << COL_W;
  localparam int SCAN_CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STEP_CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [SCAN_CW-1:0] SCAN_LAST = SCAN_CW'(SCAN_DIV - 1);
  localparam logic [STEP_CW-1:0] STEP_LAST = STEP_CW'(STEP_DIV - 1);

  // ---------------------------------------------------------------------------
  // Glyph RAM: register array, combinational read.
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0] ram [WORDS];

  // NOTE: the RAM has no reset on purpose; clearing a storage array costs a
  // reset fan-out to every bit and its contents are defined only by writes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Dividers and tick generation
  // ---------------------------------------------------------------------------
  logic [SCAN_CW-1:0] scan_cnt;
  logic [STEP_CW-1:0] step_cnt;
  logic               scan_tick;
  logic               step_term;
  logic               step_tick;

  assign scan_tick = (scan_cnt == SCAN_LAST);
  assign step_term = (step_cnt == STEP_LAST);
  // The step divider free-runs through pause so the cadence of steps is
  // unchanged by a pause; only the tick itself is masked.
  assign step_tick = step_term && !pause;

  // ---------------------------------------------------------------------------
  // Next-column, read address and next-base computation
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    base;
  logic [AW-1:0]    base_nxt;
  logic [AW-1:0]    rd_addr;
  logic [COL_W-1:0] col_nxt;
  logic [GW-1:0]    glyph_nxt;

  assign col_nxt   = col + COL_W'(1);
  // Read the column being stepped to, so row and col update together. The
  // adder wraps naturally at 2**AW, which makes scroll mode seamless.
  assign rd_addr   = base + {{GW{1'b0}}, col_nxt};
  // Dropping the column bits rounds an unaligned base down to its glyph.
  assign glyph_nxt = base[AW-1:COL_W] + GW'(1);

  // NOTE: every signal assigned in always_comb gets its default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    base_nxt = {glyph_nxt, {COL_W{1'b0}}};
`ifdef DOT_SCROLL_EN
    if (mode) begin
      base_nxt = base + AW'(1);
    end
`endif
  end

`ifndef DOT_SCROLL_EN
  // Page-only build: mode has no function.
  logic unused_mode;
  assign unused_mode = mode;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; in particular the row load below sees the old
  // base when scan_tick and step_tick coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      step_cnt <= '0;
      col      <= '0;
      row      <= '0;
      base     <= '0;
      wrap     <= 1'b0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + SCAN_CW'(1);
      step_cnt <= step_term ? '0 : step_cnt + STEP_CW'(1);
      wrap     <= 1'b0;

      if (scan_tick) begin
        col <= col_nxt;
        // A write to rd_addr on this same edge is not yet visible here, so
        // the old word is displayed until the next visit.
        row <= en ? ram[rd_addr] : '0;
      end

      if (step_tick) begin
        base <= base_nxt;
        wrap <= (base_nxt == '0);
      end
    end
  end

endmodule
